jserial_alu: RTL and testbench

Bit-serial arithmetic/compare sequencer for the jcscpu datapath: it reuses one `jadd` cell and one `jcmp` cell across an N-bit word, one bit per clock, instead of instantiating N ripple slices. It captures operands on a start handshake, walks the bits with a counter-driven state machine, holds carry/compare state in flops between bits, and presents the registered result with a one-cycle done pulse. It sits between the instruction stepper and the register bus as a low-area ALU alternative.

---
 rtl/jserial_alu.sv | 181 ++++++++++++++++++
 tb/tb_jserial_alu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jserial_alu.sv
// Bit-serial ADD/CMP sequencer: one add cell and one compare cell walked across an N-bit word.
// Optional compare datapath is built only when JSERIAL_ALU_CMP_EN is defined.
module jserial_alu #(
  parameter int unsigned N = 8
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         wstart,
  input  logic         wop,
  input  logic [N-1:0] wa,
  input  logic [N-1:0] wb,
  input  logic         wci,
  output logic         wbusy,
  output logic         wdone,
  output logic [N-1:0] wc,
  output logic         wco,
  output logic         weq,
  output logic         wal
);

  localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          carry_q, carry_d;
  logic          last_bit;

  logic [N-1:0]  wc_q;
  logic          wco_q;

  // Shared full-adder cell, always fed from the LSB end of the operand shifters.
  logic add_s, add_co;
  assign add_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign add_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

`ifdef JSERIAL_ALU_CMP_EN
  logic op_q, op_d;
  logic eq_q, eq_d, al_q, al_d;
  logic weq_q, wal_q;

  // Shared compare cell, fed MSB first; "al" latches once a higher bit decides A > B.
  logic cmp_c, cmp_eq, cmp_al;
  assign cmp_c  = a_q[N-1] ^ b_q[N-1];
  assign cmp_eq = eq_q & ~cmp_c;
  assign cmp_al = al_q | (eq_q & a_q[N-1] & ~b_q[N-1]);
`else
  logic unused_wop;
  assign unused_wop = wop;
`endif

  assign last_bit = (st_q == StRun) && (cnt_q == CntLast);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
`ifdef JSERIAL_ALU_CMP_EN
    op_d    = op_q;
    eq_d    = eq_q;
    al_d    = al_q;
`endif
    unique case (st_q)
      StIdle: begin
        if (wstart) begin
          st_d    = StRun;
          cnt_d   = '0;
          a_d     = wa;
          b_d     = wb;
          res_d   = '0;
          carry_d = wci;
`ifdef JSERIAL_ALU_CMP_EN
          op_d    = wop;
          eq_d    = 1'b1;
          al_d    = 1'b0;
`endif
        end
      end
      StRun: begin
`ifdef JSERIAL_ALU_CMP_EN
        if (op_q) begin
          a_d   = a_q << 1;
          b_d   = b_q << 1;
          res_d = {res_q[N-2:0], cmp_c};
          eq_d  = cmp_eq;
          al_d  = cmp_al;
        end else begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          res_d   = {add_s, res_q[N-1:1]};
          carry_d = add_co;
        end
`else
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {add_s, res_q[N-1:1]};
        carry_d = add_co;
`endif
        if (cnt_q == CntLast) begin
          st_d  = StDone;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  // Result registers load only on the edge that finishes the last bit.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wc_q  <= '0;
      wco_q <= 1'b0;
    end else if (last_bit) begin
      wc_q  <= res_d;
`ifdef JSERIAL_ALU_CMP_EN
      wco_q <= op_q ? 1'b0 : carry_d;
`else
      wco_q <= carry_d;
`endif
    end
  end

`ifdef JSERIAL_ALU_CMP_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      op_q  <= 1'b0;
      eq_q  <= 1'b0;
      al_q  <= 1'b0;
      weq_q <= 1'b0;
      wal_q <= 1'b0;
    end else begin
      op_q <= op_d;
      eq_q <= eq_d;
      al_q <= al_d;
      if (last_bit) begin
        weq_q <= op_q & eq_d;
        wal_q <= op_q & al_d;
      end
    end
  end

  assign weq = weq_q;
  assign wal = wal_q;
`else
  assign weq = 1'b0;
  assign wal = 1'b0;
`endif

  assign wbusy = (st_q == StRun);
  assign wdone = (st_q == StDone);
  assign wc    = wc_q;
  assign wco   = wco_q;

endmodule

// File: tb/tb_jserial_alu.sv
// Bench for jserial_alu: directed and random ADD/CMP requests against an arithmetic model.
// CMP expectations apply only when JSERIAL_ALU_CMP_EN is defined; otherwise every request is ADD.
module tb_jserial_alu;

  localparam int unsigned N = 8;
`ifdef JSERIAL_ALU_CMP_EN
  localparam bit CmpBuilt = 1'b1;
`else
  localparam bit CmpBuilt = 1'b0;
`endif

  logic         wclk, wrst_n, wstart, wop, wci;
  logic [N-1:0] wa, wb, wc;
  logic         wbusy, wdone, wco, weq, wal;

  int vectors;
  int miscompares;

  jserial_alu #(.N(N)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wstart (wstart),
    .wop    (wop),
    .wa     (wa),
    .wb     (wb),
    .wci    (wci),
    .wbusy  (wbusy),
    .wdone  (wdone),
    .wc     (wc),
    .wco    (wco),
    .weq    (weq),
    .wal    (wal)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic model(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, output logic [N-1:0] c, output logic co,
                       output logic eq, output logic al);
    logic [N:0] s;
    if (op && CmpBuilt) begin
      c  = a ^ b;
      co = 1'b0;
      eq = (a == b);
      al = (a > b);
    end else begin
      s  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
      c  = s[N-1:0];
      co = s[N];
      eq = 1'b0;
      al = 1'b0;
    end
  endtask

  // Called in the low clock phase; returns one clock after the done pulse.
  task automatic do_op(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input string name);
    logic [N-1:0] ec;
    logic         eco, eeq, eal;
    int           busy_n, lat;
    bit           seen;
    model(op, a, b, ci, ec, eco, eeq, eal);
    wstart = 1'b1; wop = op; wa = a; wb = b; wci = ci;
    @(posedge wclk);
    #1;
    wstart = 1'b0; wa = N'($urandom); wb = N'($urandom); wci = 1'($urandom); wop = 1'($urandom);
    busy_n = 0; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 2 * N + 4 && !seen; i++) begin
      @(negedge wclk);
      if (wbusy && wdone) begin
        miscompares++;
        $display("FAIL %s busy_and_done: both high at sample %0d", name, i);
      end
      if (wbusy) busy_n++;
      if (wdone) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: wdone not seen, required within %0d cycles", name, N + 1);
      return;
    end
    vectors++;
    if (lat !== N + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, N + 1);
    end
    vectors++;
    if (busy_n !== N) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_n, N);
    end
    vectors++;
    if (wc !== ec) begin
      miscompares++;
      $display("FAIL %s wc: got %h required %h", name, wc, ec);
    end
    vectors++;
    if ({wco, weq, wal} !== {eco, eeq, eal}) begin
      miscompares++;
      $display("FAIL %s flags(co,eq,al): got %b required %b", name, {wco, weq, wal},
               {eco, eeq, eal});
    end
    @(negedge wclk);
    vectors++;
    if ({wdone, wbusy} !== 2'b00 || wc !== ec) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%b busy=%b wc=%h required 0 0 %h", name, wdone,
               wbusy, wc, ec);
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; wstart = 1'b0; wop = 1'b0; wa = '0; wb = '0; wci = 1'b0;
    @(negedge wclk);
    vectors++;
    if ({wbusy, wdone, wc, wco, weq, wal} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b wc=%h co=%b eq=%b al=%b required all 0",
               wbusy, wdone, wc, wco, weq, wal);
    end
    wrst_n = 1'b1;
  endtask

  task automatic test_add_directed();
    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op(1'b0, 8'h00, 8'h00, 1'b1, "add_00_00_ci");
    do_op(1'b0, 8'hFF, 8'hFF, 1'b1, "add_ff_ff_ci");
  endtask

  task automatic test_cmp_directed();
    do_op(1'b1, 8'h80, 8'h7F, 1'b0, "cmp_80_7f");
    do_op(1'b1, 8'h33, 8'h33, 1'b1, "cmp_33_33");
    do_op(1'b1, 8'h10, 8'h11, 1'b0, "cmp_10_11");
    do_op(1'b1, 8'h05, 8'h03, 1'b0, "op1_05_03");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      do_op(1'($urandom), N'($urandom), N'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    logic [N-1:0] ec;
    logic         eco, eeq, eal;
    int           done_n, late_busy;
    bit           seen;
    model(1'b0, 8'h12, 8'h34, 1'b1, ec, eco, eeq, eal);
    wstart = 1'b1; wop = 1'b0; wa = 8'h12; wb = 8'h34; wci = 1'b1;
    @(posedge wclk);
    #1 wstart = 1'b0;
    done_n = 0; late_busy = 0; seen = 1'b0;
    for (int i = 1; i <= 3 * N; i++) begin
      @(negedge wclk);
      if (wdone) begin
        done_n++;
        seen = 1'b1;
      end else if (seen && wbusy) begin
        late_busy++;
      end
      // Requests while running (i==3) and while done must both be dropped.
      wstart = (i == 3) || wdone;
      if (wstart) begin
        wop = 1'($urandom); wa = N'($urandom); wb = N'($urandom); wci = 1'($urandom);
      end
    end
    wstart = 1'b0;
    vectors++;
    if (done_n !== 1) begin
      miscompares++;
      $display("FAIL ignore_start done_pulses: got %0d required 1", done_n);
    end
    vectors++;
    if (late_busy !== 0) begin
      miscompares++;
      $display("FAIL ignore_start restarted: got %0d busy cycles after done required 0",
               late_busy);
    end
    vectors++;
    if ({wc, wco} !== {ec, eco}) begin
      miscompares++;
      $display("FAIL ignore_start result: got %h/%b required %h/%b", wc, wco, ec, eco);
    end
  endtask

  task automatic test_reset_midrun();
    int done_n;
    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, "pre_reset");
    wstart = 1'b1; wop = 1'b0; wa = 8'hA5; wb = 8'h5A; wci = 1'b1;
    @(posedge wclk);
    #1 wstart = 1'b0;
    repeat (4) @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    vectors++;
    if ({wbusy, wdone, wc, wco, weq, wal} !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun clear: got busy=%b done=%b wc=%h co=%b eq=%b al=%b required 0",
               wbusy, wdone, wc, wco, weq, wal);
    end
    done_n = 0;
    repeat (N + 2) begin
      @(negedge wclk);
      if (wdone || wbusy) done_n++;
    end
    vectors++;
    if (done_n !== 0) begin
      miscompares++;
      $display("FAIL reset_midrun activity: got %0d busy/done cycles required 0", done_n);
    end
    wrst_n = 1'b1;
    do_op(1'b0, 8'hC3, 8'h4E, 1'b1, "post_reset");
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 8'hF0, 8'h0F, 1'b0, "b2b_0");
    do_op(1'b0, 8'h80, 8'h80, 1'b0, "b2b_1");
    do_op(1'b1, 8'h00, 8'h00, 1'b1, "b2b_2");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add_directed();
    test_cmp_directed();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
